// File: rtl/iq_demod_integrator_pkg.sv
// Shared definitions for the I/Q demodulating integrator and its consumers.
// Holds the default datapath widths, the FSM state encoding, the 32-bit I/Q
// result width seen by the readout analysis FSM, and the output saturator.
package iq_demod_integrator_pkg;

  localparam int DEF_ADC_W     = 12;
  localparam int DEF_PHASE_W   = 16;
  localparam int DEF_LUT_AW    = 8;
  localparam int DEF_LUT_W     = 12;
  localparam int DEF_LEN_W     = 16;
  localparam int DEF_OUT_SHIFT = 8;

  // Width of the i_val/q_val words handed to the analysis FSM.
  localparam int IQ_W = 32;

  // Width of the saturator input; shifted accumulators are sign-extended to it.
  localparam int SAT_IN_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_INTEG = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Clamp to [-2^(IQ_W-1), 2^(IQ_W-1)-1]. The value fits when every bit from
  // the MSB down to the result sign bit is identical.
  function automatic logic signed [IQ_W-1:0] sat_iq(input logic signed [SAT_IN_W-1:0] v);
    logic [SAT_IN_W-IQ_W:0] top;
    top = v[SAT_IN_W-1:IQ_W-1];
    if (top == '0 || top == '1) begin
      return v[IQ_W-1:0];
    end else if (v[SAT_IN_W-1]) begin
      return {1'b1, {(IQ_W-1){1'b0}}};
    end else begin
      return {1'b0, {(IQ_W-1){1'b1}}};
    end
  endfunction

endpackage

// File: rtl/iq_demod_integrator_nco.sv
// nco_sincos_lut: registered phase-address to signed cos/sin lookup.
// Ports:
//   clk100 : clock
//   addr_i : LUT address (top LUT_AW bits of the NCO phase)
//   cos_o  : round(A*cos(2*pi*addr/2^LUT_AW)), A = 2^(LUT_W-1)-1, 1-cycle latency
//   sin_o  : same for sin
// Table contents are computed at elaboration, so the ROM needs no external
// memory image and always matches the LUT_AW/LUT_W parameters.
module nco_sincos_lut #(
  parameter int LUT_AW = 8,
  parameter int LUT_W  = 12
) (
  input  logic                     clk100,
  input  logic [LUT_AW-1:0]        addr_i,
  output logic signed [LUT_W-1:0]  cos_o,
  output logic signed [LUT_W-1:0]  sin_o
);

  localparam int DEPTH = 1 << LUT_AW;

  function automatic logic signed [LUT_W-1:0] tab(input int k, input bit want_sin);
    real amp, ang, v;
    int  r;
    amp = real'((1 << (LUT_W - 1)) - 1);
    ang = 2.0 * 3.14159265358979323846 * real'(k) / real'(DEPTH);
    v   = amp * (want_sin ? $sin(ang) : $cos(ang));
    // Round half away from zero.
    r   = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    return LUT_W'(r);
  endfunction

  logic signed [LUT_W-1:0] cos_rom [DEPTH];
  logic signed [LUT_W-1:0] sin_rom [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    localparam logic signed [LUT_W-1:0] COS_K = tab(k, 1'b0);
    localparam logic signed [LUT_W-1:0] SIN_K = tab(k, 1'b1);
    assign cos_rom[k] = COS_K;
    assign sin_rom[k] = SIN_K;
  end

  always_ff @(posedge clk100) begin
    cos_o <= cos_rom[addr_i];
    sin_o <= sin_rom[addr_i];
  end

endmodule

// File: rtl/iq_demod_integrator.sv
// iq_demod_integrator: down-converts the ADC stream with an internal NCO and
// integrates I/Q over int_len accepted samples, one result pair per shot.
// Ports:
//   clk100, rst (async, active-high)
//   trig, int_len, phase_inc   : shot start and its latched settings
//   adc_data, adc_valid        : signed sample stream
//   i_val, q_val, iq_valid     : saturated results + one-cycle strobe
//   busy                       : shot in progress (INTEG or FLUSH)
//   trig_dropped               : trig seen while a shot is running
module iq_demod_integrator
  import iq_demod_integrator_pkg::*;
#(
  parameter int ADC_W     = DEF_ADC_W,
  parameter int PHASE_W   = DEF_PHASE_W,
  parameter int LUT_AW    = DEF_LUT_AW,
  parameter int LUT_W     = DEF_LUT_W,
  parameter int LEN_W     = DEF_LEN_W,
  parameter int OUT_SHIFT = DEF_OUT_SHIFT
) (
  input  logic                    clk100,
  input  logic                    rst,
  input  logic                    trig,
  input  logic [LEN_W-1:0]        int_len,
  input  logic [PHASE_W-1:0]      phase_inc,
  input  logic signed [ADC_W-1:0] adc_data,
  input  logic                    adc_valid,
  output logic signed [IQ_W-1:0]  i_val,
  output logic signed [IQ_W-1:0]  q_val,
  output logic                    iq_valid,
  output logic                    busy,
  output logic                    trig_dropped
);

  localparam int PROD_W = ADC_W + LUT_W;
  // Wide enough for 2^LEN_W full-scale products: no internal overflow.
  localparam int ACC_W  = PROD_W + LEN_W;

  state_e               state_q, state_d;
  logic [LEN_W-1:0]     len_q, len_d, count_q, count_d, count_inc;
  logic [PHASE_W-1:0]   inc_q, inc_d, phase_q, phase_d;
  logic                 accept, clr_acc, load_out;

  logic                     vld_p1_q, vld_p2_q;
  logic signed [ADC_W-1:0]  x_p1_q;
  logic signed [LUT_W-1:0]  cos_p1, sin_p1;
  logic signed [PROD_W-1:0] pi_p2_q, pq_p2_q;
  logic signed [ACC_W-1:0]  acc_i_q, acc_i_d, acc_q_q, acc_q_d;
  logic signed [ACC_W-1:0]  acc_i_sh, acc_q_sh;

  assign count_inc = count_q + LEN_W'(1);

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    inc_d        = inc_q;
    phase_d      = phase_q;
    count_d      = count_q;
    accept       = 1'b0;
    clr_acc      = 1'b0;
    load_out     = 1'b0;
    trig_dropped = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A zero-length trig is ignored outright.
        if (trig && int_len != '0) begin
          len_d   = int_len;
          inc_d   = phase_inc;
          phase_d = '0;
          count_d = '0;
          clr_acc = 1'b1;
          state_d = ST_INTEG;
        end
      end
      ST_INTEG: begin
        trig_dropped = trig;
        if (adc_valid) begin
          accept  = 1'b1;
          phase_d = phase_q + inc_q;
          count_d = count_inc;
          if (count_inc == len_q) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        trig_dropped = trig;
        // Once both stage valids are low the last product is in the accumulator.
        if (!vld_p1_q && !vld_p2_q) begin
          load_out = 1'b1;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        trig_dropped = trig;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q == ST_INTEG) || (state_q == ST_FLUSH);

  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      inc_q   <= '0;
      phase_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      inc_q   <= inc_d;
      phase_q <= phase_d;
      count_q <= count_d;
    end
  end

  // ---- stage 1: LUT read and sample delay ----
  nco_sincos_lut #(
    .LUT_AW (LUT_AW),
    .LUT_W  (LUT_W)
  ) u_lut (
    .clk100 (clk100),
    .addr_i (phase_q[PHASE_W-1 -: LUT_AW]),
    .cos_o  (cos_p1),
    .sin_o  (sin_p1)
  );

  always_ff @(posedge clk100) begin
    x_p1_q <= adc_data;
  end

  // ---- stage 2: products ----
  always_ff @(posedge clk100) begin
    pi_p2_q <= PROD_W'(x_p1_q) * PROD_W'(cos_p1);
    pq_p2_q <= PROD_W'(x_p1_q) * PROD_W'(sin_p1);
  end

  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      vld_p1_q <= accept;
      vld_p2_q <= vld_p1_q;
    end
  end

  // ---- stage 3: accumulate (Q is subtracted: mixing with e^{-j*phi}) ----
  always_comb begin
    acc_i_d = acc_i_q;
    acc_q_d = acc_q_q;
    if (clr_acc) begin
      acc_i_d = '0;
      acc_q_d = '0;
    end else if (vld_p2_q) begin
      acc_i_d = acc_i_q + ACC_W'(pi_p2_q);
      acc_q_d = acc_q_q - ACC_W'(pq_p2_q);
    end
  end

  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      acc_i_q <= '0;
      acc_q_q <= '0;
    end else begin
      acc_i_q <= acc_i_d;
      acc_q_q <= acc_q_d;
    end
  end

  // ---- output: scale, saturate, hold until next shot ----
  assign acc_i_sh = acc_i_q >>> OUT_SHIFT;
  assign acc_q_sh = acc_q_q >>> OUT_SHIFT;

  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      i_val    <= '0;
      q_val    <= '0;
      iq_valid <= 1'b0;
    end else begin
      iq_valid <= load_out;
      if (load_out) begin
        i_val <= sat_iq({{(SAT_IN_W-ACC_W){acc_i_sh[ACC_W-1]}}, acc_i_sh});
        q_val <= sat_iq({{(SAT_IN_W-ACC_W){acc_q_sh[ACC_W-1]}}, acc_q_sh});
      end
    end
  end

endmodule

// File: tb/tb_iq_demod_integrator.sv
module tb_iq_demod_integrator;

  logic               clk100 = 1'b0;
  logic               rst;
  logic               trig;
  logic [15:0]        int_len;
  logic [15:0]        phase_inc;
  logic signed [11:0] adc_data;
  logic               adc_valid;
  logic signed [31:0] i_val, q_val, i_val_s, q_val_s;
  logic               iq_valid, busy, trig_dropped;
  logic               iq_valid_s, busy_s, trig_dropped_s;

  int checks   = 0;
  int failures = 0;

  always #5 clk100 = ~clk100;

  iq_demod_integrator u_dut (
    .clk100(clk100), .rst(rst), .trig(trig), .int_len(int_len),
    .phase_inc(phase_inc), .adc_data(adc_data), .adc_valid(adc_valid),
    .i_val(i_val), .q_val(q_val), .iq_valid(iq_valid), .busy(busy),
    .trig_dropped(trig_dropped)
  );

  // Same stimulus, no output shift: exposes the saturator.
  iq_demod_integrator #(.OUT_SHIFT(0)) u_sat (
    .clk100(clk100), .rst(rst), .trig(trig), .int_len(int_len),
    .phase_inc(phase_inc), .adc_data(adc_data), .adc_valid(adc_valid),
    .i_val(i_val_s), .q_val(q_val_s), .iq_valid(iq_valid_s), .busy(busy_s),
    .trig_dropped(trig_dropped_s)
  );

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  function automatic logic signed [11:0] samp(input int smode, input int n);
    case (smode)
      0: return 12'sd100;
      1: case (n % 4) 0: return 12'sd100; 2: return -12'sd100; default: return 12'sd0; endcase
      2: return 12'sd2047;
      default: case (n % 4) 1: return 12'sd100; 3: return -12'sd100; default: return 12'sd0; endcase
    endcase
  endfunction

  // One shot: trig in cycle 0, samples from cycle 1; extra samples offered
  // after the last one must be ignored.
  task automatic shot(input int len, input int inc, input int vmode, input int smode,
                      input int drop_at,
                      output logic signed [31:0] gi, output logic signed [31:0] gq,
                      output logic signed [31:0] si, output logic signed [31:0] sq,
                      output int nstrobe, output int strobe_cyc, output int last_acc,
                      output int busy_err, output int drops);
    int k, acc;
    logic v;
    gi = '0; gq = '0; si = '0; sq = '0;
    nstrobe = 0; strobe_cyc = -1; last_acc = -1; busy_err = 0; drops = 0;
    @(posedge clk100); #1;
    trig = 1'b1; int_len = 16'(len); phase_inc = 16'(inc);
    adc_valid = 1'b0; adc_data = '0;
    @(negedge clk100);
    if (busy !== 1'b0) busy_err++;
    k = 0; acc = 0;
    while (k < 4000) begin
      @(posedge clk100); #1;
      k++;
      trig = (k == drop_at);
      if (acc < len) begin
        v = (vmode == 0) || (k % 2 == 1);
        adc_valid = v;
        adc_data  = v ? samp(smode, acc) : 12'sd555;
        if (v) begin acc++; last_acc = k; end
      end else begin
        adc_valid = 1'b1;
        adc_data  = -12'sd1234;
      end
      @(negedge clk100);
      if (trig_dropped) drops++;
      if (iq_valid) begin
        nstrobe++;
        if (strobe_cyc < 0) begin
          strobe_cyc = k;
          gi = i_val; gq = q_val; si = i_val_s; sq = q_val_s;
          if (busy !== 1'b0) busy_err++;
        end
      end else if (strobe_cyc < 0 && busy !== 1'b1) begin
        busy_err++;
      end
      if (strobe_cyc >= 0 && k >= strobe_cyc + 4) break;
    end
    trig = 1'b0; adc_valid = 1'b0;
  endtask

  typedef struct {
    int     len, inc, vmode, smode, drop_at;
    longint ei, eq, esi, esq;
    int     edrops;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic signed [31:0] gi, gq, si, sq;
    int ns, sc, la, be, dr;

    vecs[0] = '{4, 0,     0, 0, 0, 3198,     0,     818800,     0,       0};
    vecs[1] = '{4, 16384, 0, 1, 0, 1599,     0,     409400,     0,       0};
    vecs[2] = '{1024, 0,  0, 2, 0, 16760836, 0,     2147483647, 0,       0};
    vecs[3] = '{4, 0,     1, 0, 0, 3198,     0,     818800,     0,       0};
    vecs[4] = '{4, 0,     0, 0, 2, 3198,     0,     818800,     0,       1};
    vecs[5] = '{4, 16384, 0, 3, 0, 0,        -1600, 0,          -409400, 0};
    vecs[6] = '{4, 49152, 0, 3, 0, 0,        1599,  0,          409400,  0};

    rst = 1'b1; trig = 1'b0; int_len = '0; phase_inc = '0;
    adc_data = '0; adc_valid = 1'b0;
    #2;
    chk("rst_i_val", i_val, 0);
    chk("rst_q_val", q_val, 0);
    chk("rst_iq_valid", iq_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_trig_dropped", trig_dropped, 0);
    @(posedge clk100); #1 rst = 1'b0;

    for (int n = 0; n < 7; n++) begin
      shot(vecs[n].len, vecs[n].inc, vecs[n].vmode, vecs[n].smode, vecs[n].drop_at,
           gi, gq, si, sq, ns, sc, la, be, dr);
      chk($sformatf("v%0d_i_val", n), gi, vecs[n].ei);
      chk($sformatf("v%0d_q_val", n), gq, vecs[n].eq);
      chk($sformatf("v%0d_sat_i_val", n), si, vecs[n].esi);
      chk($sformatf("v%0d_sat_q_val", n), sq, vecs[n].esq);
      chk($sformatf("v%0d_strobes", n), ns, 1);
      chk($sformatf("v%0d_latency", n), sc - la, 4);
      chk($sformatf("v%0d_busy_err", n), be, 0);
      chk($sformatf("v%0d_drops", n), dr, vecs[n].edrops);
    end

    // Reset in the middle of INTEG: outputs clear at once, no strobe follows.
    begin
      int strobes;
      @(posedge clk100); #1;
      trig = 1'b1; int_len = 16'd4; phase_inc = '0; adc_valid = 1'b0;
      @(posedge clk100); #1;
      trig = 1'b0; adc_valid = 1'b1; adc_data = 12'sd100;
      @(posedge clk100); #2;
      rst = 1'b1;
      #1;
      chk("midrst_i_val", i_val, 0);
      chk("midrst_q_val", q_val, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_iq_valid", iq_valid, 0);
      @(posedge clk100); #1 rst = 1'b0;
      strobes = 0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk100);
        if (iq_valid) strobes++;
      end
      chk("midrst_no_strobe", strobes, 0);
      adc_valid = 1'b0;
      shot(4, 0, 0, 0, 0, gi, gq, si, sq, ns, sc, la, be, dr);
      chk("postrst_i_val", gi, 3198);
      chk("postrst_q_val", gq, 0);
      chk("postrst_strobes", ns, 1);
      chk("postrst_latency", sc - la, 4);
    end

    // trig with int_len=0 is ignored: no busy, no drop pulse, no strobe.
    begin
      int nb, nd, nv;
      nb = 0; nd = 0; nv = 0;
      @(posedge clk100); #1;
      trig = 1'b1; int_len = '0; adc_valid = 1'b1; adc_data = 12'sd100;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk100);
        if (busy) nb++;
        if (trig_dropped) nd++;
        if (iq_valid) nv++;
      end
      trig = 1'b0; adc_valid = 1'b0;
      chk("len0_busy", nb, 0);
      chk("len0_drops", nd, 0);
      chk("len0_strobes", nv, 0);
      chk("len0_i_hold", i_val, 3198);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
